// File: rtl/serial_pe_mac.sv
// Serial processing element: signed 16x16 multiply feeding a 32-bit
// wrapping accumulator. The controller streams element pairs tagged with
// first/last bits, and the PE returns each finished dot product with a
// one-cycle vld_o strobe. The multiplier is a radix-4 Booth encoder
// followed by a carry-save tree and a single final adder.

module serial_pe_booth_mul (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  // 3:2 compressor on 32-bit words; returns {carry, sum}, carry pre-shifted
  function automatic logic [63:0] csa(input logic [31:0] x,
                                      input logic [31:0] y,
                                      input logic [31:0] z);
    logic [31:0] s;
    logic [31:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  // multiplier padded with the implicit b[-1] = 0 bit for Booth grouping
  logic [16:0] bx;
  logic [31:0] pp [8];
  logic [7:0]  neg_bits;
  logic [31:0] corr;

  assign bx = {b, 1'b0};

  for (genvar i = 0; i < 8; i++) begin : g_booth
    logic [2:0]  grp;
    logic        one;
    logic        two;
    logic [17:0] mag;
    logic [17:0] mag_n;

    assign grp   = bx[2*i+2 : 2*i];
    assign one   = grp[0] ^ grp[1];
    assign two   = (grp[2] & ~grp[1] & ~grp[0]) | (~grp[2] & grp[1] & grp[0]);
    // one's-complement here; the +1 of the negation is added via corr
    assign mag   = one ? {{2{a[15]}}, a} : (two ? {a[15], a, 1'b0} : 18'd0);
    assign mag_n = grp[2] ? ~mag : mag;
    assign pp[i] = {{14{mag_n[17]}}, mag_n} << (2 * i);
    assign neg_bits[i] = grp[2];
  end

  // gather the negation carry-ins into one extra operand for the tree
  always_comb begin
    corr = '0;
    for (int i = 0; i < 8; i++) begin
      corr[2*i] = neg_bits[i];
    end
  end

  // carry-save reduction 9 -> 6 -> 4 -> 3 -> 2 operands
  logic [31:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5, s6, c6;

  assign {c0, s0} = csa(pp[0], pp[1], pp[2]);
  assign {c1, s1} = csa(pp[3], pp[4], pp[5]);
  assign {c2, s2} = csa(pp[6], pp[7], corr);
  assign {c3, s3} = csa(s0, c0, s1);
  assign {c4, s4} = csa(c1, s2, c2);
  assign {c5, s5} = csa(s3, c3, s4);
  assign {c6, s6} = csa(s5, c5, c4);

  assign p = s6 + c6;

endmodule

module serial_pe_mac (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] neuron,
  input  logic [15:0] weight,
  input  logic [1:0]  ctl,
  input  logic        vld_i,
  output logic [31:0] result,
  output logic        vld_o
);

  logic [31:0] product;
  logic [31:0] prod_q;
  logic        vld_q;
  logic        first_q;
  logic        last_q;
  logic [31:0] acc;
  logic [31:0] acc_next;

  serial_pe_booth_mul u_mul (
    .a (neuron),
    .b (weight),
    .p (product)
  );

  // stage 1: capture the product with its valid and first/last tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      prod_q  <= product;
      vld_q   <= vld_i;
      first_q <= ctl[0];
      last_q  <= ctl[1];
    end
  end

  // a first element restarts the sum so back-to-back vectors never mix
  assign acc_next = first_q ? prod_q : acc + prod_q;

  // stage 2: accumulate valid elements, publish the sum on a last element
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      result <= '0;
      vld_o  <= 1'b0;
    end else begin
      vld_o <= vld_q & last_q;
      if (vld_q) begin
        acc <= acc_next;
        if (last_q) begin
          result <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_pe_mac.sv
// Directed self-checking bench for serial_pe_mac. Inputs change 1ns after
// each falling edge, outputs are compared at that same point, and a monitor
// on the falling edge records every vld_o pulse with its result.

module tb_serial_pe_mac;

  logic        clk;
  logic        rst_n;
  logic [15:0] neuron;
  logic [15:0] weight;
  logic [1:0]  ctl;
  logic        vld_i;
  logic [31:0] result;
  logic        vld_o;

  int          checks;
  int          failures;
  int          pulse_cnt;
  logic [31:0] last_res;
  logic [31:0] res_q [$];
  logic [31:0] exp_q [$];

  serial_pe_mac dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .neuron (neuron),
    .weight (weight),
    .ctl    (ctl),
    .vld_i  (vld_i),
    .result (result),
    .vld_o  (vld_o)
  );

  // free-running 10ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // record every output strobe together with the result it carries
  always @(negedge clk) begin
    if (vld_o === 1'b1) begin
      pulse_cnt = pulse_cnt + 1;
      last_res  = result;
      res_q.push_back(result);
    end
  end

  // hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [15:0] n, input logic [15:0] w,
                               input logic [1:0] c, input logic v);
    @(negedge clk);
    #1;
    neuron = n;
    weight = w;
    ctl    = c;
    vld_i  = v;
  endtask

  // bubble cycles carry garbage operands and ctl that must be ignored
  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), 2'($urandom), 1'b0);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic runSingle(input string tag, input logic [15:0] n,
                           input logic [15:0] w, input logic [31:0] exp);
    applyStimulus(n, w, 2'b11, 1'b1);
    idle(1);
    checkOutput({tag, "_vld_early"}, 32'(vld_o), 32'd0);
    idle(1);
    checkOutput({tag, "_vld"}, 32'(vld_o), 32'd1);
    checkOutput({tag, "_result"}, result, exp);
    idle(1);
    checkOutput({tag, "_vld_off"}, 32'(vld_o), 32'd0);
  endtask

  task automatic runVector(input string tag, input logic [15:0] n,
                           input logic [15:0] w, input int len,
                           input bit bubbles, input logic [31:0] exp);
    int base;
    base = pulse_cnt;
    for (int i = 0; i < len; i++) begin
      if (bubbles) idle(int'($urandom_range(0, 2)));
      applyStimulus(n, w, {(i == len - 1), (i == 0)}, 1'b1);
    end
    idle(3);
    checkOutput({tag, "_pulses"}, 32'(pulse_cnt - base), 32'd1);
    checkOutput({tag, "_result"}, last_res, exp);
  endtask

  initial begin
    int               lens [4];
    int               base;
    logic [15:0]      n;
    logic [15:0]      w;
    logic signed [31:0] p_model;
    logic [31:0]      sum;

    checks    = 0;
    failures  = 0;
    pulse_cnt = 0;
    last_res  = '0;
    rst_n     = 1'b0;
    neuron    = '0;
    weight    = '0;
    ctl       = '0;
    vld_i     = 1'b0;

    $display("[TB] reset and single element");
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_vld", 32'(vld_o), 32'd0);
    rst_n = 1'b1;
    applyStimulus(16'h0003, 16'h0004, 2'b11, 1'b1);
    idle(1);
    checkOutput("first_vld_early", 32'(vld_o), 32'd0);
    checkOutput("first_result_early", result, 32'd0);
    idle(1);
    checkOutput("first_vld", 32'(vld_o), 32'd1);
    checkOutput("first_result", result, 32'h0000000C);
    idle(1);
    checkOutput("first_vld_off", 32'(vld_o), 32'd0);
    checkOutput("first_result_hold", result, 32'h0000000C);

    $display("[TB] signed and extreme operands");
    runSingle("neg_x_two", 16'hFFFF, 16'h0002, 32'hFFFFFFFE);
    runSingle("min_x_max", 16'h8000, 16'h7FFF, 32'hC0008000);
    runSingle("min_x_min", 16'h8000, 16'h8000, 32'h40000000);
    runSingle("max_x_max", 16'h7FFF, 16'h7FFF, 32'h3FFF0001);
    runSingle("neg_x_neg", 16'hFFFD, 16'hFFF9, 32'h00000015);
    runVector("wrap2", 16'h8000, 16'h8000, 2, 1'b0, 32'h80000000);

    $display("[TB] two consecutive single-element vectors");
    applyStimulus(16'h0002, 16'h0003, 2'b11, 1'b1);
    applyStimulus(16'hFFFF, 16'hFFFF, 2'b11, 1'b1);
    idle(1);
    checkOutput("pair_a_vld", 32'(vld_o), 32'd1);
    checkOutput("pair_a_result", result, 32'h00000006);
    idle(1);
    checkOutput("pair_b_vld", 32'(vld_o), 32'd1);
    checkOutput("pair_b_result", result, 32'h00000001);
    idle(1);
    checkOutput("pair_vld_off", 32'(vld_o), 32'd0);

    $display("[TB] 32-element vectors");
    runVector("vec32", 16'h0001, 16'h0002, 32, 1'b0, 32'h00000040);
    runVector("vec32_bubbles", 16'h0001, 16'h0002, 32, 1'b1, 32'h00000040);

    $display("[TB] back-to-back random vectors");
    lens = '{1, 2, 32, 64};
    res_q.delete();
    exp_q.delete();
    for (int v = 0; v < 4; v++) begin
      sum = '0;
      for (int i = 0; i < lens[v]; i++) begin
        n = 16'($urandom);
        w = 16'($urandom);
        p_model = $signed(n) * $signed(w);
        sum = sum + p_model;
        applyStimulus(n, w, {(i == lens[v] - 1), (i == 0)}, 1'b1);
      end
      exp_q.push_back(sum);
    end
    idle(3);
    checkOutput("b2b_pulses", 32'(res_q.size()), 32'd4);
    for (int v = 0; v < 4; v++) begin
      if (v < res_q.size()) begin
        checkOutput($sformatf("b2b_vec%0d", v), res_q[v], exp_q[v]);
      end else begin
        checkOutput($sformatf("b2b_vec%0d_missing", v), 32'hxxxxxxxx, exp_q[v]);
      end
    end

    $display("[TB] reset in the middle of a vector");
    base = pulse_cnt;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(16'h0001, 16'h0002, {1'b0, (i == 0)}, 1'b1);
    end
    applyStimulus(16'h0001, 16'h0002, 2'b10, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    vld_i = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("midrst_vld", 32'(vld_o), 32'd0);
    checkOutput("midrst_result", result, 32'd0);
    rst_n = 1'b1;
    idle(3);
    checkOutput("midrst_no_stale", 32'(pulse_cnt - base), 32'd0);
    runVector("last_only_after_rst", 16'h0002, 16'h0003, 1, 1'b0, 32'h00000006);
    applyStimulus(16'h0002, 16'h0003, 2'b10, 1'b1);
    idle(3);
    checkOutput("last_only_accum", last_res, 32'h0000000C);
    runVector("fresh_vec", 16'h0003, 16'h0005, 4, 1'b0, 32'h0000003C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
